// File: rtl/det_pkg.sv
// Shared types and constants for the cyclic-diagonal determinant engine.
package det_pkg;

    typedef enum logic [1:0] {
        SARRUS = 2'b00,
        FWD    = 2'b01,
        ANTI   = 2'b10,
        RSVD   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DIAG_END,
        FINISH
    } state_e;

    // Every diagonal product starts from this value.
    localparam int PROD_SEED = 1;

endpackage

// File: rtl/det_mac.sv
// Running diagonal product and signed accumulator, both kept modulo 2^ACC_W.
module det_mac
    import det_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int ACC_W  = 2*DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_acc,
    input  logic                     clr_prod,
    input  logic                     mul_en,
    input  logic                     acc_en,
    input  logic                     sub,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [ACC_W-1:0]  acc_next
);

    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] prod_next;
    logic signed [ACC_W-1:0] term;

    assign x_ext     = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
    // ACC_W-wide context: the product is truncated to the low ACC_W bits.
    assign prod_next = prod * x_ext;
    assign term      = mul_en ? prod_next : prod;
    assign acc_next  = sub ? (acc - term) : (acc + term);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod <= ACC_W'(PROD_SEED);
            acc  <= '0;
        end else begin
            if (clr_prod)
                prod <= ACC_W'(PROD_SEED);
            else if (mul_en)
                prod <= prod_next;
            if (clr_acc)
                acc <= '0;
            else if (acc_en)
                acc <= acc_next;
        end
    end

endmodule

// File: rtl/det_diag_engine.sv
// Walks forward/anti cyclic diagonals of an N x N matrix over a one-outstanding
// read port and writes the signed sum/difference of the diagonal products.
module det_diag_engine
    import det_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 20,
    parameter int ACC_W  = 2*DATA_W,
    parameter int N_MAX  = 64,
    parameter int NW     = $clog2(N_MAX+1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NW-1:0]            n,
    input  logic [1:0]               mode,
    output logic                     rd_req,
    output logic [ADDR_W-1:0]        rd_row,
    output logic [ADDR_W-1:0]        rd_col,
    input  logic                     rd_valid,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     wr_en,
    output logic signed [ACC_W-1:0]  wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam logic [NW-1:0] ONE = NW'(1);

    state_e  state, state_nxt;
    mode_e   mode_r;
    logic [NW-1:0] n_r, k_r, t_r, row_r;
    logic [NW-1:0] last_idx, last_k, anti_first, row_step;
    logic    anti_r, err_r;
    logic    legal, pair2, has_anti, last_elem, last_diag, last_pass;
    logic    clr_acc, clr_prod, mul_en, acc_en, sub;
    logic signed [ACC_W-1:0] acc_next;

    assign legal      = (n != '0) && (n <= NW'(N_MAX)) && (mode_e'(mode) != RSVD);
    assign last_idx   = n_r - ONE;
    // A 2x2 SARRUS only needs forward k=0 and anti k=1.
    assign pair2      = (mode_r == SARRUS) && (n_r == NW'(2));
    assign has_anti   = (mode_r == SARRUS) && (n_r != ONE);
    assign anti_first = pair2 ? ONE : '0;
    assign last_k     = (pair2 && !anti_r) ? '0 : last_idx;
    assign last_elem  = (t_r == last_idx);
    assign last_diag  = (k_r == last_k);
    assign last_pass  = anti_r || !has_anti;

    always_comb begin
        if (anti_r)
            row_step = (row_r == '0) ? last_idx : (row_r - ONE);
        else
            row_step = (row_r == last_idx) ? '0 : (row_r + ONE);
    end

    assign rd_row = ADDR_W'(row_r);
    assign rd_col = ADDR_W'(t_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        busy      = 1'b0;
        clr_acc   = 1'b0;
        clr_prod  = 1'b0;
        mul_en    = 1'b0;
        acc_en    = 1'b0;
        sub       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_acc   = legal;
                    clr_prod  = legal;
                    state_nxt = legal ? REQ : FINISH;
                end
            end
            REQ: begin
                rd_req    = 1'b1;
                busy      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (rd_valid) begin
                    mul_en = 1'b1;
                    if (last_elem) begin
                        acc_en    = 1'b1;
                        sub       = anti_r && (mode_r == SARRUS);
                        state_nxt = (last_diag && last_pass) ? FINISH : DIAG_END;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            DIAG_END: begin
                // First read of the next diagonal goes out while the product restarts.
                rd_req    = 1'b1;
                busy      = 1'b1;
                clr_prod  = 1'b1;
                state_nxt = WAIT;
            end
            FINISH: begin
                done      = 1'b1;
                wr_en     = !err_r;
                error     = err_r;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_r     <= '0;
            mode_r  <= SARRUS;
            err_r   <= 1'b0;
            anti_r  <= 1'b0;
            k_r     <= '0;
            t_r     <= '0;
            row_r   <= '0;
            wr_data <= '0;
        end else if (state == IDLE && start) begin
            n_r    <= n;
            mode_r <= mode_e'(mode);
            err_r  <= !legal;
            anti_r <= (mode_e'(mode) == ANTI) && (n != ONE);
            k_r    <= '0;
            t_r    <= '0;
            row_r  <= '0;
        end else if (state == WAIT && rd_valid) begin
            if (!last_elem) begin
                t_r   <= t_r + ONE;
                row_r <= row_step;
            end else if (last_diag && last_pass) begin
                wr_data <= acc_next;
            end else if (last_diag) begin
                anti_r <= 1'b1;
                k_r    <= anti_first;
                row_r  <= anti_first;
                t_r    <= '0;
            end else begin
                k_r   <= k_r + ONE;
                row_r <= k_r + ONE;
                t_r   <= '0;
            end
        end
    end

    det_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr_acc  (clr_acc),
        .clr_prod (clr_prod),
        .mul_en   (mul_en),
        .acc_en   (acc_en),
        .sub      (sub),
        .x        (rd_data),
        .acc_next (acc_next)
    );

endmodule

// File: tb/tb_det_diag_engine.sv
// Randomised bench for det_diag_engine against a modular-arithmetic diagonal model.
module tb_det_diag_engine;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int ACC_W  = 16;
    localparam int N_MAX  = 8;
    localparam int NW     = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [NW-1:0]            n;
    logic [1:0]               mode;
    logic                     rd_req;
    logic [ADDR_W-1:0]        rd_row, rd_col;
    logic                     rd_valid;
    logic signed [DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ACC_W-1:0]         wr_data;
    logic                     busy, done, error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mat [0:7][0:7];
    int lat_cfg = 1;
    bit resp_en = 1'b1;
    bit inject_valid = 1'b0;
    int pend = 0;
    int pr = 0, pc = 0;
    int lat_sum = 0;
    int got_reads[$];
    int exp_reads[$];
    longint exp_res;
    logic [ACC_W-1:0] last_res;
    int last_reads;

    det_diag_engine #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .ACC_W  (ACC_W),
        .N_MAX  (N_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n        (n),
        .mode     (mode),
        .rd_req   (rd_req),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Memory model: answers each request after a fixed or random latency.
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            rd_valid = inject_valid;
            rd_data  = 8'sh55;
            if (reset || !resp_en) pend = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = DATA_W'(mat[pr][pc]);
                end
            end
            if (rd_req === 1'b1 && !reset) begin
                pr = (int'(rd_row) < N_MAX) ? int'(rd_row) : 0;
                pc = (int'(rd_col) < N_MAX) ? int'(rd_col) : 0;
                got_reads.push_back(int'(rd_row) * 64 + int'(rd_col));
                pend = (lat_cfg == 0) ? int'($urandom_range(1, 6)) : lat_cfg;
                lat_sum += pend;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic longint wrap16(input longint v);
        return v & 64'hFFFF;
    endfunction

    task automatic add_diag(input int nn, input bit anti, input int k, input int sign);
        longint p;
        int r;
        p = 1;
        for (int t = 0; t < nn; t++) begin
            r = anti ? ((((k - t) % nn) + nn) % nn) : ((k + t) % nn);
            exp_reads.push_back(r * 64 + t);
            p = wrap16(p * mat[r][t]);
        end
        exp_res = wrap16(exp_res + sign * p);
    endtask

    task automatic build_model(input int nn, input int md);
        exp_reads.delete();
        exp_res = 0;
        if (nn == 1) begin
            add_diag(1, 1'b0, 0, 1);
        end else begin
            if (md != 2)
                for (int k = 0; k < nn; k++)
                    if (!(md == 0 && nn == 2 && k != 0)) add_diag(nn, 1'b0, k, 1);
            if (md != 1)
                for (int k = 0; k < nn; k++)
                    if (!(md == 0 && nn == 2 && k != 1)) add_diag(nn, 1'b1, k, (md == 0) ? -1 : 1);
        end
    endtask

    task automatic run_job(input string tag, input int nn, input int md, input int lat, input bit poke);
        int s, base, lbase, waited, bad, nreads;
        bit legal;
        logic [ACC_W-1:0] prev;
        legal = (nn >= 1 && nn <= N_MAX && md != 3);
        if (legal) build_model(nn, md);
        else exp_reads.delete();
        lat_cfg = lat;
        @(negedge clk);
        base  = got_reads.size();
        lbase = lat_sum;
        prev  = wr_data;
        start = 1'b1;
        n     = NW'(nn);
        mode  = 2'(md);
        s     = cyc;
        @(negedge clk);
        start = 1'b0;
        if (legal) begin
            chk({tag, "_busy1"}, busy, 1);
            chk({tag, "_req1"}, rd_req, 1);
        end
        if (poke) begin
            @(negedge clk);
            start = 1'b1;
            n     = NW'(2);
            mode  = 2'd1;
            @(negedge clk);
            start = 1'b0;
        end
        waited = 0;
        while (done !== 1'b1 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (done !== 1'b1) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        nreads = got_reads.size() - base;
        chk({tag, "_error"}, error, !legal);
        chk({tag, "_wr_en"}, wr_en, legal);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_nreads"}, nreads, exp_reads.size());
        chk({tag, "_done_cycle"}, cyc - s, legal ? (lat_sum - lbase) + nreads + 1 : 1);
        if (legal) begin
            bad = -1;
            for (int i = 0; i < exp_reads.size(); i++)
                if (bad < 0 && (base + i >= got_reads.size() || got_reads[base + i] != exp_reads[i]))
                    bad = i;
            chk({tag, "_order"}, bad, -1);
            chk({tag, "_result"}, wr_data, exp_res[15:0]);
        end else begin
            chk({tag, "_wr_hold"}, wr_data, prev);
        end
        last_res   = wr_data;
        last_reads = nreads;
        @(negedge clk);
        chk({tag, "_pulse_end"}, {done, wr_en, error}, 0);
    endtask

    task automatic load3();
        mat[0][0] = 2; mat[0][1] = 0; mat[0][2] = 1;
        mat[1][0] = 1; mat[1][1] = 3; mat[1][2] = 2;
        mat[2][0] = 1; mat[2][1] = 1; mat[2][2] = 4;
    endtask

    initial begin
        int nn, md;
        reset        = 1'b1;
        start        = 1'b0;
        n            = '0;
        mode         = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mat[r][c] = 0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {rd_req, wr_en, busy, done, error}, 0);
        chk("rst_addr", {rd_row, rd_col}, 0);
        chk("rst_wr_data", wr_data, 0);
        reset = 1'b0;

        load3();
        run_job("sar3", 3, 0, 1, 0);
        chk("sar3_value", last_res, 18);
        chk("sar3_reads", last_reads, 18);
        run_job("fwd3", 3, 1, 1, 0);
        chk("fwd3_value", last_res, 25);
        run_job("anti3", 3, 2, 1, 0);
        chk("anti3_value", last_res, 7);
        run_job("sar3_rlat", 3, 0, 0, 1);
        chk("sar3_rlat_value", last_res, 18);

        mat[0][0] = -3; mat[0][1] = 5;
        mat[1][0] = 2;  mat[1][1] = 4;
        run_job("sar2", 2, 0, 1, 0);
        chk("sar2_value", last_res, 16'hFFEA);
        chk("sar2_reads", last_reads, 4);

        mat[0][0] = -7;
        for (int m = 0; m < 3; m++) begin
            run_job($sformatf("n1_m%0d", m), 1, m, 1, 0);
            chk($sformatf("n1_m%0d_value", m), last_res, 16'hFFF9);
        end

        run_job("err_n0", 0, 0, 1, 0);
        run_job("err_nbig", N_MAX + 1, 0, 1, 0);
        run_job("err_mode", 3, 3, 1, 0);

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) mat[r][c] = -128;
        run_job("neg128", 3, 0, 1, 0);
        chk("neg128_value", last_res, 0);

        // Busy start, reset while waiting on a read, then a stray response.
        load3();
        resp_en = 1'b0;
        lat_cfg = 1;
        @(negedge clk);
        start = 1'b1;
        n     = NW'(3);
        mode  = 2'd0;
        @(negedge clk);
        n     = NW'(2);
        mode  = 2'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_ctrl", {rd_req, wr_en, busy, done, error}, 0);
        chk("rst_mid_addr", {rd_row, rd_col}, 0);
        chk("rst_mid_wr_data", wr_data, 0);
        @(negedge clk);
        reset   = 1'b0;
        resp_en = 1'b1;
        @(posedge clk);
        inject_valid = 1'b1;
        @(negedge clk);
        #1 inject_valid = 1'b0;
        @(negedge clk);
        chk("late_valid_ignored", {rd_req, wr_en, busy, done, error}, 0);
        run_job("after_rst", 3, 0, 1, 0);
        chk("after_rst_value", last_res, 18);

        for (int it = 0; it < 8; it++) begin
            nn = $urandom_range(1, N_MAX);
            md = $urandom_range(0, 2);
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) mat[r][c] = int'($urandom_range(0, 255)) - 128;
            run_job($sformatf("rnd%0d_n%0d_m%0d", it, nn, md), nn, md, int'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
